// File: rtl/gray_clk_gen.sv
// Gray-coded clock divider: binary count b -> registered gray_clk -> registered tap/quadrature taps.
// Define GRAY_SINE_EN to build the q_sine quadrature output; otherwise q_sine is tied to 0.
module gray_clk_gen #(
   parameter int W  = 11,
   parameter int SW = 4
) (
   input  logic          clk_master,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic [SW-1:0] tap_sel,
   output logic [W-1:0]  gray_clk,
   output logic          q_tap,
   output logic          q_sine,
   output logic          wrap
);

   logic [W-1:0] b;
   logic         tap_bit;

   // Explicit compare mux so tap_sel >= W selects nothing and yields 0.
   always_comb begin
      tap_bit = 1'b0;
      for (int k = 0; k < W; k++)
         if (tap_sel == SW'(k)) tap_bit = gray_clk[k];
   end

   // clr flushes the whole pipeline so the restart looks identical to a reset.
   always_ff @(posedge clk_master) begin
      if (rst || clr) begin
         b        <= '0;
         gray_clk <= '0;
         q_tap    <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         wrap <= en && (&b);
         if (en) begin
            b        <= b + 1'b1;
            gray_clk <= b ^ (b >> 1);
            q_tap    <= tap_bit;
         end
      end
   end

`ifdef GRAY_SINE_EN
   logic [W-1:0] b_d;
   logic         sine_bit;

   // b_d is the binary value aligned with gray_clk; b_d[k+1] trails gray_clk[k] by a quarter period.
   always_comb begin
      sine_bit = 1'b0;
      for (int k = 0; k < W-1; k++)
         if (tap_sel == SW'(k)) sine_bit = b_d[k+1];
   end

   always_ff @(posedge clk_master) begin
      if (rst || clr) begin
         b_d    <= '0;
         q_sine <= 1'b0;
      end else if (en) begin
         b_d    <= b;
         q_sine <= sine_bit;
      end
   end
`else
   assign q_sine = 1'b0;
`endif

endmodule

// File: tb/tb_gray_clk_gen.sv
// Self-checking bench for gray_clk_gen (W=4): count-based reference model plus literal spot checks.
module tb_gray_clk_gen;
   localparam int W  = 4;
   localparam int SW = 4;
   localparam int M  = 1 << W;

   logic          clk_master = 1'b0;
   logic          rst = 1'b1, en = 1'b0, clr = 1'b0;
   logic [SW-1:0] tap_sel = '0;
   logic [W-1:0]  gray_clk;
   logic          q_tap, q_sine, wrap;

   int n_chk = 0, n_fail = 0;

   gray_clk_gen #(.W(W), .SW(SW)) dut (
      .clk_master(clk_master), .rst(rst), .en(en), .clr(clr), .tap_sel(tap_sel),
      .gray_clk(gray_clk), .q_tap(q_tap), .q_sine(q_sine), .wrap(wrap)
   );

   always #5 clk_master = ~clk_master;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int g(input int x);
      return x ^ (x >> 1);
   endfunction

   // Reference model: n = enabled edges since last reset/clear; outputs are functions of n.
   int n = 0, tap_last = 0;
   bit wrap_m = 0;

   always @(posedge clk_master) begin
      if (rst || clr) begin
         n = 0; wrap_m = 0;
      end else if (en) begin
         wrap_m = (n % M) == M-1;
         n++;
         tap_last = int'(tap_sel);
      end else
         wrap_m = 0;
   end

   always @(negedge clk_master) begin
      int eg, et, es;
      eg = (n >= 1) ? g((n-1) % M) : 0;
      et = (n >= 2 && tap_last < W) ? ((g((n-2) % M) >> tap_last) & 1) : 0;
`ifdef GRAY_SINE_EN
      es = (n >= 2 && tap_last <= W-2) ? ((((n-2) % M) >> (tap_last+1)) & 1) : 0;
`else
      es = 0;
`endif
      chk("model_gray", int'(gray_clk), eg);
      chk("model_q_tap", int'(q_tap), et);
      chk("model_q_sine", int'(q_sine), es);
      chk("model_wrap", int'(wrap), int'(wrap_m));
   end

   task automatic wait_gray(input int v, input string nm);
      int k;
      for (k = 0; k < 64 && int'(gray_clk) != v; k++) @(negedge clk_master);
      if (k == 64) chk(nm, int'(gray_clk), v);
   endtask

   initial begin
      int seq [17] = '{0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0};
      int wraps, prev, diff, hi, mis;
      bit tq [32];
      bit sq [32];
      logic [W-1:0] g0;
      logic t0, s0;

      repeat (2) @(negedge clk_master);
      chk("reset_gray", int'(gray_clk), 0);
      chk("reset_q_tap", int'(q_tap), 0);
      chk("reset_q_sine", int'(q_sine), 0);
      chk("reset_wrap", int'(wrap), 0);

      // Gray sequence after reset, one bit per step, single wrap pulse
      rst = 0; en = 1; tap_sel = 4'd1;
      wraps = 0; prev = 0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk_master);
         chk("seq_gray", int'(gray_clk), seq[i]);
         if (i > 0) begin
            diff = prev ^ int'(gray_clk);
            chk("seq_one_bit", $countones(diff), 1);
         end
         prev = int'(gray_clk);
         wraps += int'(wrap);
      end
      chk("seq_wrap_count", wraps, 1);

      // Quadrature on tap 1 over 32 cycles
      for (int i = 0; i < 32; i++) begin
         @(negedge clk_master);
         tq[i] = q_tap; sq[i] = q_sine;
      end
      hi = 0; mis = 0;
      for (int i = 0; i < 32; i++) hi += int'(tq[i]);
      chk("quad_tap_duty", hi, 16);
      for (int i = 2; i < 32; i++)
`ifdef GRAY_SINE_EN
         if (sq[i] != tq[i-2]) mis++;
`else
         if (sq[i]) mis++;
`endif
      chk("quad_sine_lag", mis, 0);

      // Hold with en low
      wait_gray(6, "wait_gray6");
      en = 0; g0 = gray_clk; t0 = q_tap; s0 = q_sine;
      repeat (5) begin
         @(negedge clk_master);
         chk("hold_gray", int'(gray_clk), int'(g0));
         chk("hold_q", int'({q_tap, q_sine}), int'({t0, s0}));
         chk("hold_wrap", int'(wrap), 0);
      end
      en = 1;
      @(negedge clk_master);
      chk("hold_next", int'(gray_clk), 7);

      // clr and rst+clr from gray D
      wait_gray(13, "wait_grayD");
      clr = 1;
      @(negedge clk_master);
      chk("clr_gray", int'(gray_clk), 0);
      chk("clr_wrap", int'(wrap), 0);
      clr = 0;
      wait_gray(13, "wait_grayD2");
      clr = 1; rst = 1;
      @(negedge clk_master);
      chk("rstclr_gray", int'(gray_clk), 0);
      chk("rstclr_q", int'({q_tap, q_sine}), 0);
      chk("rstclr_wrap", int'(wrap), 0);
      clr = 0; rst = 0;

      // Out-of-range tap
      tap_sel = 4'd9;
      repeat (3) @(negedge clk_master);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_master);
         hi += int'(q_tap) + int'(q_sine);
      end
      chk("tap9_zero", hi, 0);

      // Randomized traffic, checked by the model on every cycle
      for (int i = 0; i < 3000; i++) begin
         en      = ($urandom_range(0, 3) != 0);
         clr     = ($urandom_range(0, 39) == 0);
         rst     = ($urandom_range(0, 99) == 0);
         tap_sel = SW'($urandom_range(0, 15));
         @(negedge clk_master);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
